light_sequencer: RTL
====================

LIGHT_SEQUENCER -- requirements
Module: light_sequencer

Interface
REQ-001 Parameter STEP_W, default 8: width of the step-period input and the step timer.
REQ-002 Parameter HOLD_STEPS, default 4: number of step ticks the lamp bank is held fully lit.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  2  request lines from requesters 0 and 1; level-sensitive.
REQ-006 step_len  input  STEP_W  step period in clk cycles; sampled only at grant.
REQ-007 grant  output  2  one-hot owner of the lamp bank; 00 when idle.
REQ-008 busy  output  1  high whenever the state is not IDLE.
REQ-009 done  output  1  one-cycle pulse when a sequence completes.
REQ-010 lamp  output  3  thermometer-coded lamp drive.

Function
REQ-011 The FSM SHALL have the states IDLE, UP, HOLD and DOWN.
REQ-012 In IDLE, lamp SHALL be 000, grant 00 and busy 0.
REQ-013 In IDLE with any req bit high, the next edge SHALL enter UP, set the winner's grant bit and latch step_len.
REQ-014 Arbitration SHALL be round-robin:
- A single requester wins.
- If both requesters are high, the one not granted last wins.
- After reset, the last-granted pointer is 1, so requester 0 wins first.
REQ-015 The step period SHALL be the latched step_len cycles, with 0 treated as 1.
REQ-016 The step timer SHALL restart on every state entry and emit a tick, then wrap, after each full period.
REQ-017 In UP, each tick SHALL shift lamp: 000->001->011->111; the tick producing 111 SHALL also enter HOLD.
REQ-018 HOLD SHALL last exactly HOLD_STEPS ticks with lamp=111, then enter DOWN.
REQ-019 In DOWN, each tick SHALL shift lamp: 111->011->001->000.
REQ-020 The tick producing 000 in DOWN SHALL, on the same edge:
- enter IDLE;
- clear grant;
- assert done for exactly one cycle.
REQ-021 If the granted requester's req is low during UP or HOLD, the next edge SHALL enter DOWN from the current lamp value and restart the timer.
REQ-022 An abort from UP with lamp=000 SHALL complete on the first DOWN tick with done.
REQ-023 In DOWN, req SHALL be ignored.
REQ-024 Changes to step_len while busy SHALL have no effect.
REQ-025 The non-granted requester SHALL wait; the FSM SHALL spend at least one cycle in IDLE between sequences, and arbitration happens there.
REQ-026 Nominal duration SHALL be (6+HOLD_STEPS)×period cycles, measured from the grant edge to the done edge.
REQ-027 grant SHALL never have more than one bit set.
REQ-028 done SHALL never be asserted outside the IDLE-entry edge.

Reset
REQ-029 Asserting reset (low) SHALL immediately force:
- state=IDLE;
- lamp=000, grant=00, busy=0, done=0;
- timer=0;
- last-granted pointer=1.
REQ-030 Reset mid-sequence SHALL abandon the sequence with no done pulse.
REQ-031 After reset release, the first rising edge with req high SHALL grant normally.

Verification
REQ-032 Nominal sequence, HOLD_STEPS=4, step_len=2, req=01 held:
- grant=01 at edge 1;
- lamp 001/011/111 at edges 3/5/7;
- DOWN at edge 15;
- lamp 011/001/000 at edges 17/19/21;
- done high for one cycle after edge 21.
REQ-033 Contention, req=11 held after reset:
- requester 0 is served first;
- then one IDLE cycle;
- then grant=10 for the second sequence;
- with both still held, the third sequence grants requester 0.
REQ-034 Abort: drop req[0] while lamp=011 in UP -> next edge DOWN, lamp 001 then 000 on successive ticks, then done.
REQ-035 step_len=0 -> period 1; the full sequence from grant to done takes 10 cycles.
REQ-036 Change step_len from 2 to 7 mid-HOLD -> tick spacing stays 2 cycles until done.
REQ-037 Assert reset while lamp=111 in HOLD:
- outputs clear immediately (asynchronous);
- no done pulse;
- after release with req=10, grant=10.

Source files
------------

// File: rtl/light_sequencer_if.sv
// Handshake and lamp-drive bundle between requesters and the light sequencer.
interface light_sequencer_if #(
  parameter int STEP_W = 8
);
  logic [1:0]        req;
  logic [STEP_W-1:0] step_len;
  logic [1:0]        grant;
  logic              busy;
  logic              done;
  logic [2:0]        lamp;

  modport master (
    output req, step_len,
    input  grant, busy, done, lamp
  );

  modport slave (
    input  req, step_len,
    output grant, busy, done, lamp
  );
endinterface

// File: rtl/light_sequencer.sv
// Two-requester round-robin lamp sequencer: ramps a 3-lamp thermometer bank up,
// holds it fully lit, then ramps it down, one step per latched step period.
module light_sequencer #(
  parameter int STEP_W     = 8,
  parameter int HOLD_STEPS = 4
) (
  input  logic             clk,
  input  logic             reset,
  light_sequencer_if.slave bus
);

  localparam int HC_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_STEPS - 1);

  typedef enum logic [1:0] {IDLE, UP, HOLD, DOWN} state_e;

  state_e            state_q, state_d;
  logic [2:0]        lamp_q, lamp_d;
  logic [1:0]        grant_q, grant_d;
  logic              done_q, done_d;
  logic              last_q, last_d;
  logic [STEP_W-1:0] timer_q, timer_d;
  logic [STEP_W-1:0] len_m1_q, len_m1_d;
  logic [HC_W-1:0]   hold_q, hold_d;

  logic tick;
  logic abort;
  logic win;
  logic busy;

  assign tick  = (timer_q == len_m1_q);
  assign abort = ~|(bus.req & grant_q);

  // Round-robin: with both requesting, the one not served last wins.
  always_comb begin
    win = ~last_q;
    if (bus.req == 2'b01)      win = 1'b0;
    else if (bus.req == 2'b10) win = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      lamp_q   <= '0;
      grant_q  <= '0;
      done_q   <= 1'b0;
      last_q   <= 1'b1;
      timer_q  <= '0;
      len_m1_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      lamp_q   <= lamp_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      last_q   <= last_d;
      timer_q  <= timer_d;
      len_m1_q <= len_m1_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (|bus.req) state_d = UP;
      UP: begin
        if (abort)                           state_d = DOWN;
        else if (tick && lamp_q == 3'b011)   state_d = HOLD;
      end
      HOLD: begin
        if (abort)                           state_d = DOWN;
        else if (tick && hold_q == HOLD_LAST) state_d = DOWN;
      end
      DOWN: if (tick && lamp_q[2:1] == 2'b00) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lamp_d   = lamp_q;
    grant_d  = grant_q;
    done_d   = 1'b0;
    last_d   = last_q;
    len_m1_d = len_m1_q;
    hold_d   = hold_q;

    // Timer restarts on every state change and stays parked at zero in IDLE.
    if (state_d != state_q || state_d == IDLE || tick) timer_d = '0;
    else                                               timer_d = timer_q + STEP_W'(1);

    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_d  = win ? 2'b10 : 2'b01;
          last_d   = win;
          len_m1_d = (bus.step_len == '0) ? '0 : bus.step_len - STEP_W'(1);
          hold_d   = '0;
        end
      end
      UP:   if (!abort && tick) lamp_d = {lamp_q[1:0], 1'b1};
      HOLD: if (!abort && tick) hold_d = hold_q + HC_W'(1);
      DOWN: begin
        if (tick) begin
          lamp_d = {1'b0, lamp_q[2:1]};
          if (lamp_q[2:1] == 2'b00) begin
            grant_d = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    bus.busy  = busy;
    bus.grant = grant_q;
    bus.done  = done_q;
    bus.lamp  = lamp_q;
  end

endmodule
